// File: rtl/alu_issue_pkg.sv
// Shared constants for the ID/EX issue stage: operand selects, ALU op codes
// and the register-match helper used by forwarding.
package alu_issue_pkg;

   localparam logic [1:0] ASEL_RS1  = 2'd0;
   localparam logic [1:0] ASEL_PC   = 2'd1;
   localparam logic [1:0] ASEL_ZERO = 2'd2;
   localparam logic       BSEL_RS2  = 1'b0;
   localparam logic       BSEL_IMM  = 1'b1;

   typedef enum logic [4:0] {
      IADD, ISUB, IAND, IOR, IXOR, ISLL, ISRL, ISRA,
      ISLT, ISLTU, IEQ, INE
   } alu_op_e;

   // x0 is hardwired, so a write to it is never a forwarding source
   function automatic logic rs_match(input logic en,
                                     input logic [4:0] rd,
                                     input logic [4:0] rs);
      return en && (rd != 5'd0) && (rd == rs);
   endfunction

endpackage

// File: rtl/alu_issue_fwd_mux.sv
// Operand forwarding mux: EX result beats MEM result beats regfile,
// and x0 always reads as zero.
module alu_issue_fwd_mux
   import alu_issue_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [4:0]      rs,
   input  logic [XLEN-1:0] rf_data,
   input  logic            ex_en,
   input  logic [4:0]      ex_rd,
   input  logic [XLEN-1:0] ex_data,
   input  logic            mem_en,
   input  logic [4:0]      mem_rd,
   input  logic [XLEN-1:0] mem_data,
   output logic [XLEN-1:0] val
);

   always_comb begin
      val = rf_data;
      if (rs == 5'd0)
         val = '0;
      else if (rs_match(ex_en, ex_rd, rs))
         val = ex_data;
      else if (rs_match(mem_en, mem_rd, rs))
         val = mem_data;
   end

endmodule

// File: rtl/alu_issue.sv
// ID/EX issue stage: forwards operands, selects ALU inputs, registers them,
// and stalls on load-use with a valid/ready handshake and flush.
module alu_issue
   import alu_issue_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [XLEN-1:0]  in_pc,
   input  logic [4:0]       in_rs1,
   input  logic [4:0]       in_rs2,
   input  logic [XLEN-1:0]  in_rs1_data,
   input  logic [XLEN-1:0]  in_rs2_data,
   input  logic [XLEN-1:0]  in_imm,
   input  logic [1:0]       in_a_sel,
   input  logic             in_b_sel,
   input  logic [4:0]       in_op,
   input  logic [4:0]       in_rd,
   input  logic             in_wr_en,
   input  logic             in_is_load,
   input  logic [XLEN-1:0]  ex_result,
   input  logic             mem_wr_en,
   input  logic [4:0]       mem_rd,
   input  logic [XLEN-1:0]  mem_data,
   input  logic             flush,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [XLEN-1:0]  alu_a,
   output logic [XLEN-1:0]  alu_b,
   output logic [4:0]       alu_c,
   output logic [XLEN-1:0]  out_pc,
   output logic [4:0]       out_rd,
   output logic             out_wr_en,
   output logic             out_is_load,
   output logic [XLEN-1:0]  out_store_data,
   output logic [CNT_W-1:0] stall_cnt
);

   logic            ex_en;
   logic [XLEN-1:0] rs1v;
   logic [XLEN-1:0] rs2v;
   logic [XLEN-1:0] a_val;
   logic [XLEN-1:0] b_val;
   logic            rs1_used;
   logic            rs2_used;
   logic            hazard;
   logic            take;

   // a held load has no result yet, so it cannot feed EX forwarding
   assign ex_en = out_valid && out_wr_en && !out_is_load;

   alu_issue_fwd_mux #(.XLEN(XLEN)) u_fwd_rs1 (
      .rs       (in_rs1),
      .rf_data  (in_rs1_data),
      .ex_en    (ex_en),
      .ex_rd    (out_rd),
      .ex_data  (ex_result),
      .mem_en   (mem_wr_en),
      .mem_rd   (mem_rd),
      .mem_data (mem_data),
      .val      (rs1v)
   );

   alu_issue_fwd_mux #(.XLEN(XLEN)) u_fwd_rs2 (
      .rs       (in_rs2),
      .rf_data  (in_rs2_data),
      .ex_en    (ex_en),
      .ex_rd    (out_rd),
      .ex_data  (ex_result),
      .mem_en   (mem_wr_en),
      .mem_rd   (mem_rd),
      .mem_data (mem_data),
      .val      (rs2v)
   );

   // non-load instructions may still need rs2 as store data
   assign rs1_used = (in_a_sel == ASEL_RS1);
   assign rs2_used = (in_b_sel == BSEL_RS2) || !in_is_load;

   assign hazard = in_valid && out_valid && out_is_load && out_wr_en
                && (out_rd != 5'd0)
                && ((rs1_used && (in_rs1 == out_rd))
                 || (rs2_used && (in_rs2 == out_rd)));

   assign in_ready = !hazard && (!out_valid || out_ready) && !flush;
   assign take     = in_valid && in_ready;

   always_comb begin
      a_val = '0;
      case (in_a_sel)
         ASEL_RS1: a_val = rs1v;
         ASEL_PC:  a_val = in_pc;
         default:  a_val = '0;
      endcase
   end

   assign b_val = (in_b_sel == BSEL_IMM) ? in_imm : rs2v;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid      <= 1'b0;
         alu_a          <= '0;
         alu_b          <= '0;
         alu_c          <= IADD;
         out_pc         <= '0;
         out_rd         <= '0;
         out_wr_en      <= 1'b0;
         out_is_load    <= 1'b0;
         out_store_data <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (take) begin
         out_valid      <= 1'b1;
         alu_a          <= a_val;
         alu_b          <= b_val;
         alu_c          <= in_op;
         out_pc         <= in_pc;
         out_rd         <= in_rd;
         out_wr_en      <= in_wr_en;
         out_is_load    <= in_is_load;
         out_store_data <= rs2v;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_cnt <= '0;
      else if (hazard && !flush && (stall_cnt != '1))
         stall_cnt <= stall_cnt + 1'b1;
   end

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: reset, operand select, forwarding priority,
// load-use stalls, x0 handling, backpressure and flush.
module tb_alu_issue;
   import alu_issue_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_pc;
   logic [4:0]  in_rs1;
   logic [4:0]  in_rs2;
   logic [31:0] in_rs1_data;
   logic [31:0] in_rs2_data;
   logic [31:0] in_imm;
   logic [1:0]  in_a_sel;
   logic        in_b_sel;
   logic [4:0]  in_op;
   logic [4:0]  in_rd;
   logic        in_wr_en;
   logic        in_is_load;
   logic [31:0] ex_result;
   logic        mem_wr_en;
   logic [4:0]  mem_rd;
   logic [31:0] mem_data;
   logic        flush;
   logic        out_ready;
   logic        out_valid;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [4:0]  alu_c;
   logic [31:0] out_pc;
   logic [4:0]  out_rd;
   logic        out_wr_en;
   logic        out_is_load;
   logic [31:0] out_store_data;
   logic [15:0] stall_cnt;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   alu_issue #(.XLEN(32), .CNT_W(16)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_pc          (in_pc),
      .in_rs1         (in_rs1),
      .in_rs2         (in_rs2),
      .in_rs1_data    (in_rs1_data),
      .in_rs2_data    (in_rs2_data),
      .in_imm         (in_imm),
      .in_a_sel       (in_a_sel),
      .in_b_sel       (in_b_sel),
      .in_op          (in_op),
      .in_rd          (in_rd),
      .in_wr_en       (in_wr_en),
      .in_is_load     (in_is_load),
      .ex_result      (ex_result),
      .mem_wr_en      (mem_wr_en),
      .mem_rd         (mem_rd),
      .mem_data       (mem_data),
      .flush          (flush),
      .out_ready      (out_ready),
      .out_valid      (out_valid),
      .alu_a          (alu_a),
      .alu_b          (alu_b),
      .alu_c          (alu_c),
      .out_pc         (out_pc),
      .out_rd         (out_rd),
      .out_wr_en      (out_wr_en),
      .out_is_load    (out_is_load),
      .out_store_data (out_store_data),
      .stall_cnt      (stall_cnt)
   );

   task automatic idle();
      in_valid    = 0; in_pc  = 0; in_rs1 = 0; in_rs2 = 0;
      in_rs1_data = 0; in_rs2_data = 0; in_imm = 0;
      in_a_sel    = ASEL_RS1; in_b_sel = BSEL_RS2; in_op = IADD;
      in_rd       = 0; in_wr_en = 0; in_is_load = 0;
      ex_result   = 0; mem_wr_en = 0; mem_rd = 0; mem_data = 0;
      flush       = 0; out_ready = 1;
   endtask

   task automatic instr(input logic [31:0] pc, input logic [4:0] rs1,
                        input logic [31:0] d1, input logic [4:0] rs2,
                        input logic [31:0] d2, input logic [31:0] imm,
                        input logic [1:0] as, input logic bs,
                        input logic [4:0] rd, input logic wr,
                        input logic ld);
      in_valid = 1; in_pc = pc; in_rs1 = rs1; in_rs1_data = d1;
      in_rs2 = rs2; in_rs2_data = d2; in_imm = imm;
      in_a_sel = as; in_b_sel = bs; in_rd = rd;
      in_wr_en = wr; in_is_load = ld;
   endtask

   task automatic test_reset();
      idle(); rst_n = 0;
      @(negedge clk); rst_n = 1;
      @(negedge clk);
      instr(32'h40, 1, 5, 2, 6, 7, ASEL_RS1, BSEL_IMM, 9, 1, 0);
      in_op = ISUB;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1) begin
         failures++; $display("FAIL reset_pre_valid got=%b exp=1", out_valid);
      end
      #1 rst_n = 0; #1;
      checks++;
      if ({out_valid, out_rd, out_wr_en, out_is_load} !== 8'h0) begin
         failures++;
         $display("FAIL reset_ctrl got=%b%h%b%b exp=0", out_valid, out_rd,
                  out_wr_en, out_is_load);
      end
      checks++;
      if ({alu_a, alu_b, out_pc, out_store_data} !== 128'h0) begin
         failures++;
         $display("FAIL reset_data a=%h b=%h pc=%h sd=%h exp=0",
                  alu_a, alu_b, out_pc, out_store_data);
      end
      checks++;
      if (alu_c !== 5'(IADD) || stall_cnt !== 16'h0) begin
         failures++;
         $display("FAIL reset_op_cnt c=%h cnt=%h exp=%h/0", alu_c, stall_cnt,
                  5'(IADD));
      end
      idle();
      @(negedge clk); rst_n = 1;
      @(negedge clk);
   endtask

   task automatic test_addi();
      instr(32'h100, 1, 5, 0, 0, 7, ASEL_RS1, BSEL_IMM, 2, 1, 0);
      in_op = IADD;
      @(negedge clk);
      checks++;
      if (alu_a !== 32'd5 || alu_b !== 32'd7 || out_valid !== 1'b1) begin
         failures++;
         $display("FAIL addi a=%h b=%h v=%b exp=5/7/1", alu_a, alu_b, out_valid);
      end
      checks++;
      if (out_pc !== 32'h100 || out_rd !== 5'd2 || alu_c !== 5'(IADD)) begin
         failures++;
         $display("FAIL addi_ctrl pc=%h rd=%h c=%h", out_pc, out_rd, alu_c);
      end
      instr(32'h104, 1, 5, 6, 32'h33, 0, ASEL_PC, BSEL_RS2, 7, 1, 0);
      in_op = ISUB;
      @(negedge clk);
      checks++;
      if (alu_a !== 32'h104 || alu_b !== 32'h33 || alu_c !== 5'(ISUB)
          || out_store_data !== 32'h33) begin
         failures++;
         $display("FAIL pc_sel a=%h b=%h c=%h sd=%h exp=104/33/%h/33",
                  alu_a, alu_b, alu_c, out_store_data, 5'(ISUB));
      end
      idle();
      @(negedge clk);
   endtask

   task automatic test_ex_fwd();
      instr(32'h200, 1, 1, 2, 2, 0, ASEL_RS1, BSEL_RS2, 3, 1, 0);
      @(negedge clk);
      instr(32'h204, 3, 0, 0, 0, 0, ASEL_RS1, BSEL_IMM, 5, 1, 0);
      ex_result = 32'h10;
      @(negedge clk);
      checks++;
      if (alu_a !== 32'h10) begin
         failures++; $display("FAIL ex_fwd got=%h exp=10", alu_a);
      end
      instr(32'h208, 1, 1, 2, 2, 0, ASEL_RS1, BSEL_RS2, 3, 1, 0);
      ex_result = 0;
      @(negedge clk);
      instr(32'h20c, 3, 0, 3, 0, 0, ASEL_RS1, BSEL_RS2, 6, 1, 0);
      ex_result = 32'h10;
      mem_wr_en = 1; mem_rd = 3; mem_data = 32'h20;
      @(negedge clk);
      checks++;
      if (alu_a !== 32'h10 || alu_b !== 32'h10 || out_store_data !== 32'h10) begin
         failures++;
         $display("FAIL ex_over_mem a=%h b=%h sd=%h exp=10", alu_a, alu_b,
                  out_store_data);
      end
      instr(32'h210, 3, 0, 7, 32'h77, 0, ASEL_RS1, BSEL_RS2, 8, 1, 0);
      @(negedge clk);
      checks++;
      if (alu_a !== 32'h20 || alu_b !== 32'h77) begin
         failures++;
         $display("FAIL mem_fwd a=%h b=%h exp=20/77", alu_a, alu_b);
      end
      idle();
      @(negedge clk);
   endtask

   task automatic test_load_use();
      instr(32'h300, 1, 32'h1000, 0, 0, 4, ASEL_RS1, BSEL_IMM, 4, 1, 1);
      @(negedge clk);
      instr(32'h304, 1, 5, 4, 0, 0, ASEL_RS1, BSEL_RS2, 7, 1, 0);
      ex_result = 32'hDEAD;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         failures++; $display("FAIL lu_ready got=%b exp=0", in_ready);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || stall_cnt !== 16'd1 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL lu_bubble v=%b cnt=%0d rdy=%b exp=0/1/1", out_valid,
                  stall_cnt, in_ready);
      end
      mem_wr_en = 1; mem_rd = 4; mem_data = 32'hAB;
      @(negedge clk);
      checks++;
      if (alu_b !== 32'hAB || alu_a !== 32'd5 || out_valid !== 1'b1
          || out_store_data !== 32'hAB) begin
         failures++;
         $display("FAIL lu_mem a=%h b=%h v=%b sd=%h exp=5/ab/1/ab", alu_a,
                  alu_b, out_valid, out_store_data);
      end
      idle();
      instr(32'h308, 1, 32'h1000, 0, 0, 4, ASEL_RS1, BSEL_IMM, 4, 1, 1);
      @(negedge clk);
      instr(32'h30c, 4, 0, 0, 0, 0, ASEL_RS1, BSEL_IMM, 7, 1, 0);
      out_ready = 0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (stall_cnt !== 16'd3 || out_valid !== 1'b1 || out_pc !== 32'h308) begin
         failures++;
         $display("FAIL lu_hold cnt=%0d v=%b pc=%h exp=3/1/308", stall_cnt,
                  out_valid, out_pc);
      end
      out_ready = 1;
      instr(32'h310, 1, 5, 4, 0, 8, ASEL_RS1, BSEL_IMM, 9, 1, 1);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         failures++; $display("FAIL lu_rs2_unused got=%b exp=1", in_ready);
      end
      @(negedge clk);
      checks++;
      if (stall_cnt !== 16'd3 || out_pc !== 32'h310 || out_is_load !== 1'b1) begin
         failures++;
         $display("FAIL lu_no_stall cnt=%0d pc=%h ld=%b exp=3/310/1",
                  stall_cnt, out_pc, out_is_load);
      end
      idle();
      @(negedge clk);
   endtask

   task automatic test_x0();
      instr(32'h400, 1, 1, 2, 2, 0, ASEL_RS1, BSEL_RS2, 0, 1, 0);
      @(negedge clk);
      instr(32'h404, 0, 32'hFF, 0, 32'hFF, 0, ASEL_RS1, BSEL_RS2, 1, 1, 0);
      ex_result = 32'hFF;
      mem_wr_en = 1; mem_rd = 0; mem_data = 32'hFF;
      @(negedge clk);
      checks++;
      if (alu_a !== 32'h0 || alu_b !== 32'h0) begin
         failures++; $display("FAIL x0 a=%h b=%h exp=0/0", alu_a, alu_b);
      end
      instr(32'h408, 1, 32'h55, 2, 0, 3, ASEL_ZERO, BSEL_IMM, 1, 1, 0);
      @(negedge clk);
      checks++;
      if (alu_a !== 32'h0 || alu_b !== 32'h3) begin
         failures++; $display("FAIL zero_sel a=%h b=%h exp=0/3", alu_a, alu_b);
      end
      idle();
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      instr(32'h500, 1, 32'h11, 2, 32'h22, 0, ASEL_RS1, BSEL_RS2, 10, 1, 0);
      @(negedge clk);
      out_ready = 0;
      instr(32'h504, 1, 32'h99, 2, 32'h88, 0, ASEL_RS1, BSEL_RS2, 11, 1, 0);
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (in_ready !== 1'b0) begin
            failures++; $display("FAIL bp_ready[%0d] got=%b exp=0", i, in_ready);
         end
         @(negedge clk);
         checks++;
         if (out_pc !== 32'h500 || alu_a !== 32'h11 || alu_b !== 32'h22
             || out_rd !== 5'd10 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL bp_hold[%0d] pc=%h a=%h b=%h rd=%0d v=%b", i,
                     out_pc, alu_a, alu_b, out_rd, out_valid);
         end
      end
      flush = 1;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         failures++; $display("FAIL flush_ready got=%b exp=0", in_ready);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || out_pc !== 32'h500) begin
         failures++;
         $display("FAIL flush v=%b pc=%h exp=0/500", out_valid, out_pc);
      end
      flush = 0; out_ready = 1;
      instr(32'h508, 1, 32'h66, 2, 0, 0, ASEL_RS1, BSEL_RS2, 12, 1, 0);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'h508 || alu_a !== 32'h66) begin
         failures++;
         $display("FAIL post_flush v=%b pc=%h a=%h exp=1/508/66", out_valid,
                  out_pc, alu_a);
      end
      idle();
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_addi();
      test_ex_fwd();
      test_load_use();
      test_x0();
      test_backpressure();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
